// File: rtl/fib_ctrl_pkg.sv
// Shared encodings for the Fibonacci/Lucas sequence controller: datapath opcodes,
// controller states and mode-bit positions.
package fib_ctrl_pkg;

    localparam int OPC_NOP   = 0;
    localparam int OPC_SET1  = 1;
    localparam int OPC_SET2  = 2;
    localparam int OPC_DEC   = 3;
    localparam int OPC_LDCNT = 4;
    localparam int OPC_CHK   = 5;
    localparam int OPC_ADD   = 6;
    localparam int OPC_COPY  = 7;

    localparam int MODE_LUCAS = 0;
    localparam int MODE_CONT  = 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LDCNT = 4'd1,
        S_SEED1 = 4'd2,
        S_SEED2 = 4'd3,
        S_CHECK = 4'd4,
        S_COPY  = 4'd5,
        S_ADD   = 4'd6,
        S_MOVE  = 4'd7,
        S_DEC   = 4'd8,
        S_TEST  = 4'd9,
        S_DONE  = 4'd10,
        S_ERR   = 4'd11
    } state_e;

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Controller <-> datapath/host bundle; master is the controller side.
interface fib_seq_ctrl_if #(
    parameter int OPC_W  = 3,
    parameter int RA_W   = 2,
    parameter int ITER_W = 16
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic              zero_flag;
    logic [OPC_W-1:0]  opcode;
    logic [RA_W-1:0]   op1;
    logic [RA_W-1:0]   op2;
    logic              busy;
    logic              done;
    logic              term_valid;
    logic              err;
    logic [ITER_W-1:0] iter_cnt;

    modport master (
        input  start, abort, mode, zero_flag,
        output opcode, op1, op2, busy, done, term_valid, err, iter_cnt
    );

    modport slave (
        output start, abort, mode, zero_flag,
        input  opcode, op1, op2, busy, done, term_valid, err, iter_cnt
    );
endinterface

// File: rtl/fib_iter_wdog.sv
// Saturating term counter with a watchdog compare against MAX_ITER.
module fib_iter_wdog #(
    parameter int          ITER_W   = 16,
    parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ITER_W-1:0] cnt_o,
    output logic              hit_o
);
    logic [ITER_W-1:0] cnt_q;
    logic [ITER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == ITER_W'(MAX_ITER));
endmodule

// File: rtl/fib_seq_ctrl.sv
// Moore controller sequencing the Fibonacci/Lucas register-file + ALU datapath,
// one sequence per start (or back-to-back in continuous mode).
module fib_seq_ctrl
    import fib_ctrl_pkg::*;
#(
    parameter int          OPC_W    = 3,
    parameter int          RA_W     = 2,
    parameter int          R_NUM1   = 1,
    parameter int          R_NUM2   = 2,
    parameter int          R_TMP    = 3,
    parameter int          ITER_W   = 16,
    parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
    input  logic           clk,
    input  logic           rst,
    fib_seq_ctrl_if.master bus
);
    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       err_q, err_d;
    logic       cnt_clr, cnt_inc, cnt_hit;

    fib_iter_wdog #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (bus.iter_cnt),
        .hit_o (cnt_hit)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) mode_d = bus.mode;
                if (bus.start && !bus.abort) begin
                    state_d = S_LDCNT;
                    cnt_clr = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_LDCNT: state_d = S_SEED1;
            S_SEED1: state_d = S_SEED2;
            S_SEED2: state_d = S_CHECK;
            S_CHECK: state_d = bus.zero_flag ? S_DONE : S_COPY;
            S_COPY:  state_d = S_ADD;
            S_ADD:   state_d = S_MOVE;
            S_MOVE: begin
                state_d = S_DEC;
                cnt_inc = 1'b1;
            end
            S_DEC:   state_d = S_TEST;
            S_TEST: begin
                if (bus.zero_flag) begin
                    state_d = S_DONE;
                end else if (cnt_hit) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_COPY;
                end
            end
            S_DONE: begin
                // Continuous mode restarts a fresh sequence, so the term count restarts too.
                if (mode_q[MODE_CONT]) begin
                    state_d = S_LDCNT;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every busy-state decision, including zero_flag and the watchdog.
        if ((state_q != S_IDLE) && bus.abort) begin
            state_d = S_IDLE;
            cnt_clr = 1'b0;
            cnt_inc = 1'b0;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.opcode     = OPC_W'(OPC_NOP);
        bus.op1        = '0;
        bus.op2        = '0;
        bus.term_valid = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            S_LDCNT: bus.opcode = OPC_W'(OPC_LDCNT);
            S_SEED1: begin
                bus.opcode = OPC_W'(OPC_SET1);
                bus.op1    = RA_W'(R_NUM2);
            end
            S_SEED2: begin
                bus.opcode = mode_q[MODE_LUCAS] ? OPC_W'(OPC_SET2) : OPC_W'(OPC_SET1);
                bus.op1    = RA_W'(R_NUM1);
            end
            S_CHECK, S_TEST: bus.opcode = OPC_W'(OPC_CHK);
            S_COPY: begin
                bus.opcode = OPC_W'(OPC_COPY);
                bus.op1    = RA_W'(R_TMP);
                bus.op2    = RA_W'(R_NUM1);
            end
            S_ADD: begin
                bus.opcode = OPC_W'(OPC_ADD);
                bus.op1    = RA_W'(R_NUM1);
                bus.op2    = RA_W'(R_NUM2);
            end
            S_MOVE: begin
                bus.opcode     = OPC_W'(OPC_COPY);
                bus.op1        = RA_W'(R_NUM2);
                bus.op2        = RA_W'(R_TMP);
                bus.term_valid = 1'b1;
            end
            S_DEC:  bus.opcode = OPC_W'(OPC_DEC);
            S_DONE: bus.done   = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.err  = err_q;
endmodule
